// File: rtl/sauber_fault_pkg.sv
// sauber_fault_pkg: monitor state encoding and default sizing for wddl_fault_monitor.
package sauber_fault_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BLANK,
        ST_MONITOR,
        ST_ALARM,
        ST_CLEAR
    } state_t;
    localparam int CNT_W_DEF        = 8;
    localparam int THRESHOLD_DEF    = 1;
    localparam int BLANK_CYCLES_DEF = 2;
endpackage

// File: rtl/fault_sync.sv
// fault_sync: N-wide two-flop synchronizer for asynchronous F_ctrl lines, sync active-low reset.
module fault_sync #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);
    logic [N-1:0] r_meta;
    logic [N-1:0] r_sync;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end
    assign o_q = r_sync;
endmodule

// File: rtl/wddl_fault_monitor.sv
// wddl_fault_monitor: gathers WDDL F_ctrl flags into a sticky map, saturating count and alarm.
// SAUBER_FAULT_SYNC_EN adds a two-flop synchronizer in front of the mask (two extra edges of latency).
module wddl_fault_monitor
    import sauber_fault_pkg::*;
#(
    parameter int N_TILES      = 8,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int THRESHOLD    = THRESHOLD_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic               UserCLK,
    input  logic               rst,
    input  logic [N_TILES-1:0] f_ctrl,
    input  logic [N_TILES-1:0] mask,
    input  logic               arm,
    input  logic               clr_req,
    output logic               clr_ack,
    output logic               alarm,
    output logic               monitoring,
    output logic [N_TILES-1:0] fault_map,
    output logic [CNT_W-1:0]   fault_count
);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TH  = CNT_W'(THRESHOLD);

    state_t             r_state;
    state_t             w_next;
    logic [BW-1:0]      r_blank;
    logic [BW-1:0]      w_blank;
    logic [N_TILES-1:0] r_fault_q;
    logic [N_TILES-1:0] r_map;
    logic [N_TILES-1:0] w_map;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_hit;
    logic               r_alarm;
    logic               r_mon;
    logic               r_clr_ack;
    logic [N_TILES-1:0] w_f_in;

`ifdef SAUBER_FAULT_SYNC_EN
    fault_sync #(.N(N_TILES)) u_fault_sync (
        .i_clk   (UserCLK),
        .i_rst_n (rst),
        .i_d     (f_ctrl),
        .o_q     (w_f_in)
    );
`else
    assign w_f_in = f_ctrl;
`endif

    assign w_hit       = |r_fault_q;
    assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;

    always_comb begin
        w_next  = r_state;
        w_blank = r_blank;
        w_map   = r_map;
        w_count = r_count;
        case (r_state)
            ST_IDLE: begin
                w_blank = '0;
                if (clr_req)
                    w_next = ST_CLEAR;
                else if (arm)
                    w_next = (BLANK_CYCLES == 0) ? ST_MONITOR : ST_BLANK;
            end
            ST_BLANK: begin
                w_blank = r_blank + 1'b1;
                if (clr_req)
                    w_next = ST_CLEAR;
                else if (!arm)
                    w_next = ST_IDLE;
                else if (r_blank == BLANK_LAST)
                    w_next = ST_MONITOR;
            end
            ST_MONITOR: begin
                if (clr_req)
                    w_next = ST_CLEAR;
                else begin
                    w_map   = w_hit ? (r_map | r_fault_q) : r_map;
                    w_count = w_hit ? w_count_inc : r_count;
                    // reaching the threshold outranks a simultaneous disarm
                    if (w_count >= CNT_TH)
                        w_next = ST_ALARM;
                    else if (!arm)
                        w_next = ST_IDLE;
                end
            end
            ST_ALARM: begin
                if (clr_req)
                    w_next = ST_CLEAR;
                else begin
                    w_map   = w_hit ? (r_map | r_fault_q) : r_map;
                    w_count = w_hit ? w_count_inc : r_count;
                end
            end
            ST_CLEAR: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (w_next == ST_CLEAR) begin
            w_map   = '0;
            w_count = '0;
        end
    end

    always_ff @(posedge UserCLK) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_blank   <= '0;
            r_fault_q <= '0;
            r_map     <= '0;
            r_count   <= '0;
            r_alarm   <= 1'b0;
            r_mon     <= 1'b0;
            r_clr_ack <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_blank   <= w_blank;
            r_fault_q <= w_f_in & ~mask;
            r_map     <= w_map;
            r_count   <= w_count;
            r_alarm   <= (w_next == ST_ALARM);
            r_mon     <= (w_next == ST_MONITOR) || (w_next == ST_ALARM);
            r_clr_ack <= (w_next == ST_CLEAR);
        end
    end

    assign clr_ack     = r_clr_ack;
    assign alarm       = r_alarm;
    assign monitoring  = r_mon;
    assign fault_map   = r_map;
    assign fault_count = r_count;
endmodule
